snoop_bus_controller: RTL and testbench
=======================================

# snoop_bus_controller

Transaction sequencer and shared-bus/memory stage for the 3-node snooping cache cluster. Accepts one CPU request at a time, drives the nodes' `start`/`listen` strobes and shared operand lines, and collects snoop responses. It merges them into the bus word fed back to the requester, relays the requester's `bus_m1` code to the snoopers, performs Modified-line flushes into a 32×8 main memory, and returns per-transaction status. Sits directly upstream and downstream of the cache nodes: it produces their `bus_in` and consumes their `bus_out`.

## Interface
- No parameters; node count fixed at 3 (indices 0..2).
- `clock` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_proc` in 2: requesting node index.
- `req_op` in 1: 0 read, 1 write.
- `req_block` in 2: cache block index.
- `req_tag` in 5: tag, also the memory address.
- `req_data` in 8: write data.
- `start` out 3: one-hot start strobe to the requester node.
- `listen` out 3: listen strobes to the non-requesting nodes.
- `txn_proc` out 2: latched requester index, wired to nodes' `p0`.
- `txn_op`, `txn_block`, `txn_tag`, `txn_data` out 1/2/5/8: latched request fields, wired to nodes' `op`/`block`/`tag_in`/`wr_data`.
- `bus_in` out 12: merged bus word `{wb, hit, state[1:0], data[7:0]}` to all nodes.
- `bus_out_p0`, `bus_out_p1`, `bus_out_p2` in 12: node bus words.
- `bus_m1_p0`, `bus_m1_p1`, `bus_m1_p2` in 3: node machine-1 bus codes.
- `bus_m1_bcast` out 3: requester's code relayed to all nodes' `bus_m1_in`.
- `proc_rst` out 1: one-cycle node re-arm pulse.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 8: requester's final `bus_out[7:0]`.
- `resp_state` out 2: requester's final state.
- `resp_wb` out 1: requester's `bus_out[11]`, meaning eviction write-back required.
- `resp_err` out 1: illegal `req_proc`.

## Operation
- FSM states: IDLE, ISSUE, SNOOP, COMMIT, COLLECT, FINISH.
- **IDLE**
  - `req_valid` with `req_proc`≤2 latches the `txn_*` fields and goes to ISSUE.
  - `req_proc`==3 goes straight to FINISH with `resp_err`=1. No strobes are issued and memory is untouched.
- **ISSUE**: `start[txn_proc]`=1; `listen`=all other bits set. Nodes execute their step 0. Then go to SNOOP.
- **SNOOP**
  - Strobes are 0.
  - Scan the snooper `bus_out` words, lowest index first, and take the first with bit[10]=1 (hit). Register `bus_in` = `{0,1,00,that data}`.
  - If no snooper hits, register `bus_in` = `{0,0,00,mem[txn_tag]}`.
  - Then go to COMMIT.
- **COMMIT**: same strobes as ISSUE; nodes execute their step 1 using the registered `bus_in`. Then go to COLLECT.
- **COLLECT**
  - Strobes are 0.
  - Flush: take the lowest-index snooper with `bus_out[11]`=1 and write `mem[txn_tag]` <= its `bus_out[7:0]`.
  - The requester's wb bit is never written to memory; it is only reported on `resp_wb`.
  - Capture the requester's `bus_out[7:0]`, `[9:8]` and `[11]` into the response registers.
  - Then go to FINISH.
- **FINISH**: `resp_valid`=1 and `proc_rst`=1 for exactly one cycle. Then go to IDLE.
- `bus_m1_bcast`: combinational mux = `bus_m1_p[txn_proc]` in ISSUE through COLLECT; 0 otherwise.
- Memory
  - Reset value `mem[a]` = `{3'b000, a}`.
  - Reads are combinational; writes are synchronous, COLLECT only.
  - Write hits and write misses never update memory directly (write-back policy).
- Reset at any point: FSM returns to IDLE, all outputs go to 0 except `req_ready`=1, and memory is reinitialized. An in-flight transaction is dropped with no `resp_valid`.

## Timing
- Request handshake at edge E0 (`req_valid && req_ready`).
- State sequence after the handshake: ISSUE cycle 1, SNOOP 2, COMMIT 3, COLLECT 4, FINISH 5 (`resp_valid`).
- `req_ready` is low in cycles 1–5 and high again in cycle 6. Throughput is one transaction per 6 cycles.
- Illegal request: `resp_valid`/`resp_err` in cycle 1; `req_ready` is high again in cycle 2.
- `bus_in` changes only on the SNOOP→COMMIT edge and holds until the next SNOOP.
- `req_valid` asserted while busy is ignored; the request fields are not re-sampled.
- `resp_err` is cleared on the next accepted request.

## Test plan
- **Reset and read miss.**
  - After reset: `req_ready`=1 and all other outputs are 0.
  - Request: read, proc0, block1, tag 9; all `bus_out_p*`=0.
  - Cycle 1: `start`=001, `listen`=110.
  - Cycle 3: `bus_in`=0x009.
  - Cycle 5: `resp_valid` with `resp_data`=`bus_out_p0[7:0]`.
- **Snoop hit priority.**
  - Requester proc0. In SNOOP, `bus_out_p1`=0x620 and `bus_out_p2`=0x637.
  - `bus_in`=0x420 (proc1 wins). Memory is unchanged.
- **Flush.**
  - Request tag 12. In COLLECT, `bus_out_p2`=0xA55.
  - Result: `mem[12]`=0x55.
  - A following read miss on tag 12 with no snooper hit gives `bus_in`=0x055.
- **Illegal index.** `req_proc`=3 → `resp_valid`=1 and `resp_err`=1 in cycle 1; `start`/`listen` stay 0.
- **Reset mid-COMMIT.**
  - Outputs go to 0 immediately; no `resp_valid`.
  - `req_ready`=1 after reset; `mem[12]` reads back 0x0C.
- **Back-pressure and relay.**
  - `req_valid` held through cycles 1–5 is ignored; a second transaction starts at cycle 6.
  - With `bus_m1_p1`=3'b101 and requester proc1: `bus_m1_bcast`=101 in cycles 1–4 and 0 otherwise.

Source files
------------

// File: rtl/snoop_bus_controller.sv
// Transaction sequencer and shared-bus/memory stage for a 3-node snooping cache cluster.
// One request is in flight at a time; an accepted request completes in six cycles.
module snoop_bus_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_proc,
    input  logic        req_op,
    input  logic [1:0]  req_block,
    input  logic [4:0]  req_tag,
    input  logic [7:0]  req_data,
    output logic [2:0]  start,
    output logic [2:0]  listen,
    output logic [1:0]  txn_proc,
    output logic        txn_op,
    output logic [1:0]  txn_block,
    output logic [4:0]  txn_tag,
    output logic [7:0]  txn_data,
    output logic [11:0] bus_in,
    input  logic [11:0] bus_out_p0,
    input  logic [11:0] bus_out_p1,
    input  logic [11:0] bus_out_p2,
    input  logic [2:0]  bus_m1_p0,
    input  logic [2:0]  bus_m1_p1,
    input  logic [2:0]  bus_m1_p2,
    output logic [2:0]  bus_m1_bcast,
    output logic        proc_rst,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic [1:0]  resp_state,
    output logic        resp_wb,
    output logic        resp_err
);
    // Handshake: a request transfers on a clock edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so req_valid while busy is simply ignored.
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_SNOOP, S_COMMIT, S_COLLECT, S_FINISH
    } state_t;

    state_t      state;
    logic [7:0]  mem [32];
    logic [11:0] node_word [4];
    logic [2:0]  node_m1 [4];
    logic [11:0] req_word;
    logic [2:0]  req_m1;
    logic        snoop_hit, flush_hit;
    logic [7:0]  snoop_data, flush_data;
    logic [2:0]  req_onehot, txn_onehot;

    // Slot 3 is tied to zero so an out-of-range index never reads garbage.
    assign node_word[0] = bus_out_p0;
    assign node_word[1] = bus_out_p1;
    assign node_word[2] = bus_out_p2;
    assign node_word[3] = 12'h000;
    assign node_m1[0]   = bus_m1_p0;
    assign node_m1[1]   = bus_m1_p1;
    assign node_m1[2]   = bus_m1_p2;
    assign node_m1[3]   = 3'b000;

    assign req_word   = node_word[txn_proc];
    assign req_m1     = node_m1[txn_proc];
    assign req_onehot = 3'b001 << req_proc;
    assign txn_onehot = 3'b001 << txn_proc;

    assign bus_m1_bcast = (state == S_ISSUE || state == S_SNOOP ||
                           state == S_COMMIT || state == S_COLLECT) ? req_m1 : 3'b000;

    // Lowest-index snooper wins both the data-supply and the flush arbitration.
    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = 8'h00;
        flush_hit  = 1'b0;
        flush_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) != txn_proc) begin
                if (!snoop_hit && node_word[i][10]) begin
                    snoop_hit  = 1'b1;
                    snoop_data = node_word[i][7:0];
                end
                if (!flush_hit && node_word[i][11]) begin
                    flush_hit  = 1'b1;
                    flush_data = node_word[i][7:0];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < 32; a++) mem[a] <= 8'(a);
        end else if (state == S_COLLECT && flush_hit) begin
            mem[txn_tag] <= flush_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            start      <= 3'b000;
            listen     <= 3'b000;
            txn_proc   <= 2'd0;
            txn_op     <= 1'b0;
            txn_block  <= 2'd0;
            txn_tag    <= 5'd0;
            txn_data   <= 8'h00;
            bus_in     <= 12'h000;
            proc_rst   <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 8'h00;
            resp_state <= 2'd0;
            resp_wb    <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            start      <= 3'b000;
            listen     <= 3'b000;
            proc_rst   <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_proc == 2'd3) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            proc_rst   <= 1'b1;
                            state      <= S_FINISH;
                        end else begin
                            txn_proc  <= req_proc;
                            txn_op    <= req_op;
                            txn_block <= req_block;
                            txn_tag   <= req_tag;
                            txn_data  <= req_data;
                            resp_err  <= 1'b0;
                            start     <= req_onehot;
                            listen    <= ~req_onehot;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state <= S_SNOOP;
                S_SNOOP: begin
                    bus_in <= snoop_hit ? {4'b0100, snoop_data} : {4'b0000, mem[txn_tag]};
                    start  <= txn_onehot;
                    listen <= ~txn_onehot;
                    state  <= S_COMMIT;
                end
                S_COMMIT: state <= S_COLLECT;
                S_COLLECT: begin
                    resp_data  <= req_word[7:0];
                    resp_state <= req_word[9:8];
                    resp_wb    <= req_word[11];
                    resp_valid <= 1'b1;
                    proc_rst   <= 1'b1;
                    state      <= S_FINISH;
                end
                S_FINISH: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_bus_controller.sv
// Bench for snoop_bus_controller: a cycle-index transaction model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_snoop_bus_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_proc = 2'd0;
    logic        req_op = 1'b0;
    logic [1:0]  req_block = 2'd0;
    logic [4:0]  req_tag = 5'd0;
    logic [7:0]  req_data = 8'h00;
    logic [2:0]  start, listen;
    logic [1:0]  txn_proc;
    logic        txn_op;
    logic [1:0]  txn_block;
    logic [4:0]  txn_tag;
    logic [7:0]  txn_data;
    logic [11:0] bus_in;
    logic [11:0] bus_out_p0 = 12'h0, bus_out_p1 = 12'h0, bus_out_p2 = 12'h0;
    logic [2:0]  bus_m1_p0 = 3'b0, bus_m1_p1 = 3'b0, bus_m1_p2 = 3'b0;
    logic [2:0]  bus_m1_bcast;
    logic        proc_rst, resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_state;
    logic        resp_wb, resp_err;

    int tests = 0;
    int fails = 0;

    snoop_bus_controller dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_proc(req_proc), .req_op(req_op), .req_block(req_block), .req_tag(req_tag),
        .req_data(req_data), .start(start), .listen(listen), .txn_proc(txn_proc),
        .txn_op(txn_op), .txn_block(txn_block), .txn_tag(txn_tag), .txn_data(txn_data),
        .bus_in(bus_in), .bus_out_p0(bus_out_p0), .bus_out_p1(bus_out_p1),
        .bus_out_p2(bus_out_p2), .bus_m1_p0(bus_m1_p0), .bus_m1_p1(bus_m1_p1),
        .bus_m1_p2(bus_m1_p2), .bus_m1_bcast(bus_m1_bcast), .proc_rst(proc_rst),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_state(resp_state),
        .resp_wb(resp_wb), .resp_err(resp_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: k = cycles since handshake (0 = idle) ----------------
    int         m_k;
    logic [1:0] m_proc, m_block;
    logic       m_op;
    logic [4:0] m_tag;
    logic [7:0] m_data;
    logic [11:0] m_bus_in;
    logic [7:0] m_rdata;
    logic [1:0] m_rstate;
    logic       m_rwb, m_rerr;
    logic [7:0] m_mem [32];

    function automatic logic [11:0] bo(input int i);
        return (i == 0) ? bus_out_p0 : (i == 1) ? bus_out_p1 : (i == 2) ? bus_out_p2 : 12'h0;
    endfunction

    function automatic logic [2:0] m1(input int i);
        return (i == 0) ? bus_m1_p0 : (i == 1) ? bus_m1_p1 : (i == 2) ? bus_m1_p2 : 3'b0;
    endfunction

    task automatic model_reset();
        m_k = 0; m_proc = 0; m_block = 0; m_op = 0; m_tag = 0; m_data = 0;
        m_bus_in = 0; m_rdata = 0; m_rstate = 0; m_rwb = 0; m_rerr = 0;
        for (int a = 0; a < 32; a++) m_mem[a] = 8'(a);
    endtask

    task automatic model_advance();
        logic hit, fl;
        if (m_k == 0) begin
            if (req_valid) begin
                if (req_proc == 2'd3) begin
                    m_rerr = 1'b1;
                    m_k = 5;
                end else begin
                    m_proc = req_proc; m_op = req_op; m_block = req_block;
                    m_tag = req_tag; m_data = req_data; m_rerr = 1'b0;
                    m_k = 1;
                end
            end
        end else if (m_k == 5) begin
            m_k = 0;
        end else begin
            if (m_k == 2) begin
                hit = 1'b0;
                m_bus_in = {4'h0, m_mem[m_tag]};
                for (int i = 0; i < 3; i++)
                    if (i != int'(m_proc) && !hit && bo(i)[10]) begin
                        hit = 1'b1;
                        m_bus_in = {4'b0100, bo(i)[7:0]};
                    end
            end
            if (m_k == 4) begin
                fl = 1'b0;
                for (int i = 0; i < 3; i++)
                    if (i != int'(m_proc) && !fl && bo(i)[11]) begin
                        fl = 1'b1;
                        m_mem[m_tag] = bo(i)[7:0];
                    end
                m_rdata = bo(int'(m_proc))[7:0];
                m_rstate = bo(int'(m_proc))[9:8];
                m_rwb = bo(int'(m_proc))[11];
            end
            m_k++;
        end
    endtask

    always @(negedge clock) begin
        logic [2:0] oh;
        logic strobe;
        if (reset) model_reset();
        oh = (m_proc == 0) ? 3'b001 : (m_proc == 1) ? 3'b010 : 3'b100;
        strobe = (m_k == 1 || m_k == 3);
        chk("m.req_ready", req_ready, m_k == 0);
        chk("m.start", start, strobe ? oh : 3'b000);
        chk("m.listen", listen, strobe ? (3'b111 ^ oh) : 3'b000);
        chk("m.txn_proc", txn_proc, m_proc);
        chk("m.txn_op", txn_op, m_op);
        chk("m.txn_block", txn_block, m_block);
        chk("m.txn_tag", txn_tag, m_tag);
        chk("m.txn_data", txn_data, m_data);
        chk("m.bus_in", bus_in, m_bus_in);
        chk("m.bus_m1_bcast", bus_m1_bcast, (m_k >= 1 && m_k <= 4) ? m1(int'(m_proc)) : 3'b000);
        chk("m.proc_rst", proc_rst, m_k == 5);
        chk("m.resp_valid", resp_valid, m_k == 5);
        chk("m.resp_data", resp_data, m_rdata);
        chk("m.resp_state", resp_state, m_rstate);
        chk("m.resp_wb", resp_wb, m_rwb);
        chk("m.resp_err", resp_err, m_rerr);
        if (!reset) model_advance();
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents a request in an idle cycle; returns in cycle 1 with req_valid dropped.
    task automatic issue(input logic [1:0] p, input logic op, input logic [1:0] blk,
                         input logic [4:0] tag, input logic [7:0] d);
        req_valid = 1'b1; req_proc = p; req_op = op; req_block = blk;
        req_tag = tag; req_data = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        ticks(2);
        reset = 1'b0;
        tick();
        chk("rst.req_ready", req_ready, 1);
        chk("rst.start", start, 0);
        chk("rst.bus_in", bus_in, 0);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.txn_tag", txn_tag, 0);

        // read miss, proc0 block1 tag9
        issue(2'd0, 1'b0, 2'd1, 5'd9, 8'h00);
        chk("miss.start", start, 3'b001);
        chk("miss.listen", listen, 3'b110);
        ticks(2);
        chk("miss.bus_in", bus_in, 12'h009);
        bus_out_p0 = 12'h1A7;
        ticks(2);
        chk("miss.resp_valid", resp_valid, 1);
        chk("miss.resp_data", resp_data, 8'hA7);
        chk("miss.resp_state", resp_state, 2'd1);
        bus_out_p0 = 12'h000;
        tick();
        chk("miss.req_ready_c6", req_ready, 1);

        // snoop hit priority; requester's own hit bit must be ignored
        bus_out_p0 = 12'h4FF; bus_out_p1 = 12'h620; bus_out_p2 = 12'h637;
        issue(2'd0, 1'b0, 2'd2, 5'd3, 8'h00);
        ticks(2);
        chk("prio.bus_in", bus_in, 12'h420);
        ticks(3);
        bus_out_p0 = 12'h0; bus_out_p1 = 12'h0; bus_out_p2 = 12'h0;
        issue(2'd2, 1'b0, 2'd0, 5'd3, 8'h00);
        ticks(2);
        chk("prio.mem_unchanged", bus_in, 12'h003);
        ticks(3);

        // flush from snooper 2 into mem[12]
        issue(2'd0, 1'b0, 2'd1, 5'd12, 8'h00);
        ticks(2);
        chk("flush.bus_in_pre", bus_in, 12'h00C);
        bus_out_p2 = 12'hA55;
        ticks(2);
        bus_out_p2 = 12'h000;
        tick();
        // requester wb is reported but never written to memory
        issue(2'd1, 1'b1, 2'd1, 5'd12, 8'h3C);
        ticks(2);
        chk("flush.bus_in_post", bus_in, 12'h055);
        bus_out_p1 = 12'h8EE;
        ticks(2);
        chk("wb.resp_wb", resp_wb, 1);
        chk("wb.resp_data", resp_data, 8'hEE);
        bus_out_p1 = 12'h000;
        tick();
        issue(2'd2, 1'b0, 2'd3, 5'd12, 8'h00);
        ticks(2);
        chk("wb.mem_kept", bus_in, 12'h055);
        ticks(3);

        // illegal requester index
        req_valid = 1'b1; req_proc = 2'd3; req_tag = 5'd12;
        tick();
        req_valid = 1'b0;
        chk("ill.resp_valid", resp_valid, 1);
        chk("ill.resp_err", resp_err, 1);
        chk("ill.start", start, 0);
        chk("ill.listen", listen, 0);
        tick();
        chk("ill.req_ready_c2", req_ready, 1);

        // reset in the COMMIT cycle
        issue(2'd1, 1'b0, 2'd0, 5'd7, 8'h11);
        chk("rc.resp_err_cleared", resp_err, 0);
        ticks(2);
        chk("rc.commit_start", start, 3'b010);
        reset = 1'b1;
        #1;
        chk("rc.start", start, 0);
        chk("rc.listen", listen, 0);
        chk("rc.req_ready", req_ready, 1);
        chk("rc.txn_tag", txn_tag, 0);
        tick();
        reset = 1'b0;
        ticks(6);
        issue(2'd0, 1'b0, 2'd0, 5'd12, 8'h00);
        ticks(2);
        chk("rc.mem_reinit", bus_in, 12'h00C);
        ticks(3);

        // back-pressure and m1 relay
        bus_m1_p0 = 3'b010; bus_m1_p1 = 3'b101; bus_m1_p2 = 3'b111;
        req_valid = 1'b1; req_proc = 2'd1; req_op = 1'b0; req_block = 2'd2;
        req_tag = 5'd5; req_data = 8'h00;
        tick();
        req_tag = 5'd20;
        for (int c = 1; c <= 4; c++) begin
            chk("relay.bcast_busy", bus_m1_bcast, 3'b101);
            tick();
        end
        chk("relay.bcast_c5", bus_m1_bcast, 3'b000);
        chk("bp.txn_tag_held", txn_tag, 5'd5);
        chk("bp.resp_valid_c5", resp_valid, 1);
        tick();
        chk("bp.req_ready_c6", req_ready, 1);
        chk("relay.bcast_idle", bus_m1_bcast, 3'b000);
        tick();
        req_valid = 1'b0;
        chk("bp.second_tag", txn_tag, 5'd20);
        chk("bp.second_start", start, 3'b010);
        ticks(7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
